// File: rtl/hazard_fwd_ctrl_if.sv
// Front-end / ID-stage bundle for the hazard and forwarding controller.
// The master side drives ID-stage decode info; the slave side returns the pipeline controls.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic              rs1_used_id;
  logic              rs2_used_id;
  logic [REG_AW-1:0] rd_id;
  logic              reg_write_id;
  logic              mem_read_id;
  logic              branch_taken_ex;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              bubble_id_ex;
  logic [1:0]        fwd_a_ex;
  logic [1:0]        fwd_b_ex;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           rd_id, reg_write_id, mem_read_id, branch_taken_ex,
    input  stall_pc, stall_if_id, flush_if_id, bubble_id_ex,
           fwd_a_ex, fwd_b_ex, stall_count
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           rd_id, reg_write_id, mem_read_id, branch_taken_ex,
    output stall_pc, stall_if_id, flush_if_id, bubble_id_ex,
           fwd_a_ex, fwd_b_ex, stall_count
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall / branch flush generator and registered EX-stage forwarding selectors,
// tracking in-flight destination registers alongside the ID/EX pipeline register.
module hazard_fwd_ctrl #(
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam bit         MULTI_STALL = (STALL_CYCLES > 1);
  localparam logic [3:0] CNT_INIT    = MULTI_STALL ? 4'(STALL_CYCLES - 2) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic              ex_v;
  logic              ex_wr;
  logic              ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_wr;
  logic [REG_AW-1:0] mem_rd;
  logic [1:0]        fwd_a_q;
  logic [1:0]        fwd_b_q;
  logic [1:0]        fwd_a_nxt;
  logic [1:0]        fwd_b_nxt;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              hazard;
  logic              stall;
  logic              flush;
  logic              bubble;
  logic              issue;

  // The WB stage never feeds a forward, so only EX and MEM destinations are kept.
  always_comb begin
    hazard = bus.id_valid & ex_v & ex_ld & ex_wr &
             ((bus.rs1_used_id & (bus.rs1_id == ex_rd)) |
              (bus.rs2_used_id & (bus.rs2_id == ex_rd)));
    stall  = rst_n & ~bus.branch_taken_ex & (((state == IDLE) & hazard) | (state == STALL));
    flush  = rst_n & bus.branch_taken_ex;
    bubble = stall | flush;
    issue  = rst_n & bus.id_valid & ~bubble;
  end

  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (bus.rs1_used_id) begin
      if (ex_wr && ex_rd == bus.rs1_id)        fwd_a_nxt = 2'b01;
      else if (mem_wr && mem_rd == bus.rs1_id) fwd_a_nxt = 2'b10;
    end
    if (bus.rs2_used_id) begin
      if (ex_wr && ex_rd == bus.rs2_id)        fwd_b_nxt = 2'b01;
      else if (mem_wr && mem_rd == bus.rs2_id) fwd_b_nxt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ex_v        <= 1'b0;
      ex_wr       <= 1'b0;
      ex_ld       <= 1'b0;
      ex_rd       <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (issue) begin
        ex_v    <= 1'b1;
        ex_rd   <= bus.rd_id;
        ex_wr   <= bus.reg_write_id & (bus.rd_id != '0);
        ex_ld   <= bus.mem_read_id;
        fwd_a_q <= fwd_a_nxt;
        fwd_b_q <= fwd_b_nxt;
      end else begin
        ex_v  <= 1'b0;
        ex_rd <= '0;
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
      end

      // A resolved branch kills any stall in progress.
      if (bus.branch_taken_ex) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (hazard && MULTI_STALL) begin
              state <= STALL;
              cnt   <= CNT_INIT;
            end
          end
          STALL: begin
            if (cnt == 4'd0) state <= IDLE;
            else             cnt   <= cnt - 4'd1;
          end
          default: state <= IDLE;
        endcase
      end

      if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall_pc     = stall;
  assign bus.stall_if_id  = stall;
  assign bus.flush_if_id  = flush;
  assign bus.bubble_id_ex = bubble;
  assign bus.fwd_a_ex     = fwd_a_q;
  assign bus.fwd_b_ex     = fwd_b_q;
  assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: a single-bubble instance and a 3-bubble instance with a
// 3-bit counter, both checked every cycle against an instruction-level pipeline model.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] rs1_id = '0;
  logic [4:0] rs2_id = '0;
  logic       rs1_used_id = 1'b0;
  logic       rs2_used_id = 1'b0;
  logic [4:0] rd_id = '0;
  logic       reg_write_id = 1'b0;
  logic       mem_read_id = 1'b0;
  logic       branch_taken_ex = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus1 ();
  hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(3))  bus3 ();

  assign bus1.id_valid        = id_valid;
  assign bus1.rs1_id          = rs1_id;
  assign bus1.rs2_id          = rs2_id;
  assign bus1.rs1_used_id     = rs1_used_id;
  assign bus1.rs2_used_id     = rs2_used_id;
  assign bus1.rd_id           = rd_id;
  assign bus1.reg_write_id    = reg_write_id;
  assign bus1.mem_read_id     = mem_read_id;
  assign bus1.branch_taken_ex = branch_taken_ex;
  assign bus3.id_valid        = id_valid;
  assign bus3.rs1_id          = rs1_id;
  assign bus3.rs2_id          = rs2_id;
  assign bus3.rs1_used_id     = rs1_used_id;
  assign bus3.rs2_used_id     = rs2_used_id;
  assign bus3.rd_id           = rd_id;
  assign bus3.reg_write_id    = reg_write_id;
  assign bus3.mem_read_id     = mem_read_id;
  assign bus3.branch_taken_ex = branch_taken_ex;

  hazard_fwd_ctrl #(.REG_AW(5), .STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  hazard_fwd_ctrl #(.REG_AW(5), .STALL_CYCLES(3), .CNT_W(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Model: instructions occupying EX and MEM plus a count of committed stall cycles still owed.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  slot_t m_ex[2];
  slot_t m_mem[2];
  int    m_left[2];
  int    m_fa[2];
  int    m_fb[2];
  int    m_cnt[2];
  int    stall_len[2] = '{1, 3};
  int    cnt_max[2]   = '{65535, 7};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected)
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    else
      pass_count++;
  endtask

  function automatic bit writesReg(input slot_t s);
    return s.v && s.wr && s.rd != 0;
  endfunction

  function automatic int fwdSource(input int k, input bit used, input int rs);
    if (!used) return 0;
    if (writesReg(m_ex[k]) && m_ex[k].rd == rs) return 1;
    if (writesReg(m_mem[k]) && m_mem[k].rd == rs) return 2;
    return 0;
  endfunction

  task automatic modelStep(input int k);
    bit hazard, e_stall, e_flush, e_bub, issue;
    logic [31:0] o_spc, o_sif, o_fl, o_bub, o_fa, o_fb, o_cnt;
    slot_t nxt;
    if (k == 0) begin
      o_spc = 32'(bus1.stall_pc);  o_sif = 32'(bus1.stall_if_id);
      o_fl  = 32'(bus1.flush_if_id); o_bub = 32'(bus1.bubble_id_ex);
      o_fa  = 32'(bus1.fwd_a_ex);  o_fb  = 32'(bus1.fwd_b_ex);
      o_cnt = 32'(bus1.stall_count);
    end else begin
      o_spc = 32'(bus3.stall_pc);  o_sif = 32'(bus3.stall_if_id);
      o_fl  = 32'(bus3.flush_if_id); o_bub = 32'(bus3.bubble_id_ex);
      o_fa  = 32'(bus3.fwd_a_ex);  o_fb  = 32'(bus3.fwd_b_ex);
      o_cnt = 32'(bus3.stall_count);
    end

    hazard = id_valid && m_ex[k].ld && writesReg(m_ex[k]) &&
             ((rs1_used_id && int'(rs1_id) == m_ex[k].rd) ||
              (rs2_used_id && int'(rs2_id) == m_ex[k].rd));
    if (!rst_n) begin
      e_stall = 0; e_flush = 0; e_bub = 0;
    end else begin
      e_stall = !branch_taken_ex && (m_left[k] > 0 || hazard);
      e_flush = branch_taken_ex;
      e_bub   = e_stall || e_flush;
    end

    checkOutput($sformatf("i%0d.stall_pc", k),     o_spc, 32'(e_stall));
    checkOutput($sformatf("i%0d.stall_if_id", k),  o_sif, 32'(e_stall));
    checkOutput($sformatf("i%0d.flush_if_id", k),  o_fl,  32'(e_flush));
    checkOutput($sformatf("i%0d.bubble_id_ex", k), o_bub, 32'(e_bub));
    checkOutput($sformatf("i%0d.fwd_a_ex", k),     o_fa,  32'(m_fa[k]));
    checkOutput($sformatf("i%0d.fwd_b_ex", k),     o_fb,  32'(m_fb[k]));
    checkOutput($sformatf("i%0d.stall_count", k),  o_cnt, 32'(m_cnt[k]));

    if (!rst_n) begin
      m_ex[k] = '{0, 0, 0, 0}; m_mem[k] = '{0, 0, 0, 0};
      m_left[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_cnt[k] = 0;
    end else begin
      issue = id_valid && !e_bub;
      if (issue) begin
        m_fa[k] = fwdSource(k, rs1_used_id, int'(rs1_id));
        m_fb[k] = fwdSource(k, rs2_used_id, int'(rs2_id));
        nxt = '{1, int'(rd_id), reg_write_id, mem_read_id};
      end else begin
        nxt = '{0, 0, 0, 0};
      end
      m_mem[k] = m_ex[k];
      m_ex[k]  = nxt;
      if (branch_taken_ex)    m_left[k] = 0;
      else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
      else if (hazard)        m_left[k] = stall_len[k] - 1;
      if (e_stall && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  // Drives one ID-stage cycle after the falling edge, then checks both instances.
  task automatic applyStimulus(input bit rst, input bit v, input int r1, input bit u1,
                               input int r2, input bit u2, input int rd, input bit wr,
                               input bit ld, input bit br);
    @(negedge clk);
    rst_n = rst; id_valid = v;
    rs1_id = 5'(r1); rs1_used_id = u1;
    rs2_id = 5'(r2); rs2_used_id = u2;
    rd_id = 5'(rd); reg_write_id = wr; mem_read_id = ld;
    branch_taken_ex = br;
    #1;
    modelStep(0);
    modelStep(1);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '{0, 0, 0, 0}; m_mem[k] = '{0, 0, 0, 0};
      m_left[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_cnt[k] = 0;
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // lw x5 ; add x6,x5,x1 back to back
    applyStimulus(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(1, 1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("t1.stall1", 32'(bus1.stall_pc), 32'd1);
    checkOutput("t1.stall3", 32'(bus3.stall_pc), 32'd1);
    applyStimulus(1, 1, 5, 1, 1, 1, 6, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1.fwd_a", 32'(bus1.fwd_a_ex), 32'd2);
    nop(4);

    // add x5 ; sub x7,x5,x5 ; addi x5 x2 ; or x8,x5,x0 ; write x0 then read x0
    applyStimulus(1, 1, 1, 1, 2, 1, 5, 1, 0, 0);
    applyStimulus(1, 1, 5, 1, 5, 1, 7, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    checkOutput("t2.fwd_b", 32'(bus1.fwd_b_ex), 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    applyStimulus(1, 1, 5, 1, 0, 1, 8, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("t3.fwd_a", 32'(bus1.fwd_a_ex), 32'd1);
    applyStimulus(1, 1, 0, 1, 0, 1, 9, 1, 0, 0);
    checkOutput("t3.x0stall", 32'(bus1.stall_pc), 32'd0);
    nop(4);

    // load-use coinciding with a taken branch
    applyStimulus(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(1, 1, 5, 1, 0, 0, 6, 1, 0, 1);
    checkOutput("t4.flush", 32'(bus1.flush_if_id), 32'd1);
    checkOutput("t4.nostall", 32'(bus3.stall_pc), 32'd0);
    nop(2);

    // reset during the second stall cycle of the 3-bubble instance
    applyStimulus(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 5, 1, 6, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("t6.rst_stall", 32'(bus3.stall_pc), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6.count", 32'(bus3.stall_count), 32'd0);
    checkOutput("t6.stall", 32'(bus3.bubble_id_ex), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
